chip_clk_gen: RTL and testbench
===============================

# chip_clk_gen

Parametrised multi-channel clock generator for the PinAIpple FPGA top that drives the analog in-memory chip. It replaces the fixed divide-by-100 chip clock with NumCh independently programmable divided clocks. Each channel has a runtime half-period, an enable, and glitch-free reconfiguration at period boundaries. One-cycle rise/fall strobes let system-side logic launch chip control signals (CBL/CWL/read_out, etc.) relative to chip clock edges.

## Interface
- NumCh, 2, number of output clock channels (1..8)
- DivWidth, 8, width of half-period value
- DefaultHalf, 50, half-period loaded at reset (full period 2*DefaultHalf cycles)
- clk_sys_in  input  1  system clock; sole clock of the block
- rst_sys_in  input  1  synchronous, active-high reset
- cfg_valid_i  input  1  configuration write request
- cfg_ready_o  output  1  write accepted when valid && ready
- cfg_ch_i  input  max(1,$clog2(NumCh))  target channel
- cfg_half_i  input  DivWidth  new half-period in clk_sys_in cycles; 0 treated as 1
- cfg_en_i  input  1  new channel enable
- sync_i  input  1  phase-align pulse (see Configuration)
- clk_o  output  NumCh  divided clocks, registered
- rise_o  output  NumCh  1-cycle pulse in the cycle clk_o[c] becomes 1
- fall_o  output  NumCh  1-cycle pulse in the cycle clk_o[c] becomes 0
- busy_o  output  NumCh  channel has a pending config not yet applied

## Operation
- Per channel: counter cnt (DivWidth bits), active half_q, enable en_q, pending half_p/en_p, pending flag = busy_o[c].
- Running (en_q=1): cnt increments each cycle; when cnt == half_q-1, cnt<=0 and clk_o toggles, raising rise_o or fall_o.
- Disabled (en_q=0): clk_o held 0, cnt held 0, no strobes.
- cfg_ready_o = ~busy_o[cfg_ch_i]; for cfg_ch_i >= NumCh it is 1 and the write is dropped.
- Accepted write sets pending for that channel. Pending applies:
  - at the falling toggle of clk_o (end of full period) if running; the new half_q governs the next low phase;
  - in the cycle after acceptance if the channel is disabled.
- Disable request: the channel finishes its current period, drops clk_o at the falling toggle, then stops. No runt pulses ever.
- Enable from stopped: counting starts the cycle after apply; the first rise occurs half_q cycles later.
- Half-period 0 is clamped to 1 (clk_o toggles every cycle, period 2).
- Channels are fully independent; only sync_i couples them.

## Timing
- Reset: clk_o=0, rise_o=0, fall_o=0, busy_o=0, cnt=0, half_q=DefaultHalf, en_q=1 on all channels, cfg_ready_o=1.
- After reset release, first rise_o on each channel comes DefaultHalf cycles later.
- Steady state with half H: clk_o high H cycles, low H cycles; rise_o and fall_o are each asserted exactly 1 cycle per period.
- Write-to-apply latency: up to 2*half_q cycles when running; 1 cycle when disabled. busy_o rises the cycle after acceptance and falls in the apply cycle.
- A write in the same cycle as that channel's falling toggle is not applied that cycle; it applies at the next falling toggle.
- Reset asserted mid-operation overrides everything in that cycle, including pending configs, which are discarded.

## Configuration
- CHIPCLK_SYNC_EN defined: a sync_i pulse sets cnt<=0 and clk_o<=0 for all enabled channels next cycle, emitting fall_o for channels that were high. All pending configs apply in that same cycle; pending writes accepted in the sync_i cycle are excepted and wait for the next boundary. Channels therefore restart phase-aligned.
- CHIPCLK_SYNC_EN undefined: sync_i is ignored; channels free-run.

## Test plan
- Reset release, defaults (NumCh=2, DefaultHalf=50) -> both clk_o rise at cycle 50, fall at cycle 100, period 100; one rise_o and one fall_o per period.
- Write ch0 half=3 mid-high phase -> busy_o[0]=1, cfg_ready_o low for ch0; the current period completes at 50/50; afterwards ch0 runs 3/3, and ch1 is unaffected.
- Write ch1 en=0, then en=1 half=0 -> ch1 stops low after its falling edge with no runt; after re-enable it toggles every cycle (period 2), and busy_o is cleared 1 cycle after the re-enable write.
- Write to cfg_ch_i=3 with NumCh=2 -> ready=1, no channel state changes.
- With CHIPCLK_SYNC_EN: ch0 half=4, ch1 half=6, pulse sync_i -> both clk_o=0 next cycle, both rise 4 and 6 cycles later respectively; fall_o is pulsed only on channels that were high.
- Assert rst_sys_in while ch0 has a pending write -> next cycle all outputs are at reset values and the pending write is discarded.

Source files
------------

// File: rtl/chip_clk_gen.sv
// chip_clk_gen: NumCh independently programmable divided clocks derived from
// clk_sys_in. Each channel toggles clk_o every half_q cycles, emits one-cycle
// rise/fall strobes, and takes new settings only at the end of a full period
// (falling toggle) so the output never produces a runt pulse.
// Optional feature macro: CHIPCLK_SYNC_EN. When defined, a sync_i pulse
// restarts every enabled channel low with cnt=0 and applies all pending
// configs at once. When undefined, sync_i is ignored.
module chip_clk_gen #(
  parameter int NumCh       = 2,
  parameter int DivWidth    = 8,
  parameter int DefaultHalf = 50,
  localparam int ChW        = (NumCh > 1) ? $clog2(NumCh) : 1
) (
  input  logic                clk_sys_in,
  input  logic                rst_sys_in,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [ChW-1:0]      cfg_ch_i,
  input  logic [DivWidth-1:0] cfg_half_i,
  input  logic                cfg_en_i,
  input  logic                sync_i,
  output logic [NumCh-1:0]    clk_o,
  output logic [NumCh-1:0]    rise_o,
  output logic [NumCh-1:0]    fall_o,
  output logic [NumCh-1:0]    busy_o
);

  localparam logic [DivWidth-1:0] One     = DivWidth'(1);
  localparam logic [DivWidth-1:0] HalfRst = DivWidth'(DefaultHalf);

  logic [DivWidth-1:0] cnt_q    [NumCh];
  logic [DivWidth-1:0] cnt_d    [NumCh];
  logic [DivWidth-1:0] half_q   [NumCh];
  logic [DivWidth-1:0] half_d   [NumCh];
  logic [DivWidth-1:0] half_p_q [NumCh];
  logic [DivWidth-1:0] half_p_d [NumCh];

  logic [NumCh-1:0] en_q, en_d;
  logic [NumCh-1:0] en_p_q, en_p_d;
  logic [NumCh-1:0] busy_q, busy_d;
  logic [NumCh-1:0] clk_q, clk_d;
  logic [NumCh-1:0] rise_q, rise_d;
  logic [NumCh-1:0] fall_q, fall_d;

  logic                sync_w;
  logic                cfg_fire;
  logic [DivWidth-1:0] cfg_half_clamped;

`ifdef CHIPCLK_SYNC_EN
  assign sync_w = sync_i;
`else
  logic sync_unused;
  assign sync_unused = sync_i;
  assign sync_w      = 1'b0;
`endif

  // A zero half-period would never reach terminal count; store it as 1 so
  // half_q is always nonzero and half_q-1 never wraps.
  assign cfg_half_clamped = (cfg_half_i == '0) ? One : cfg_half_i;

  // Ready reflects the addressed channel's pending flag; out-of-range
  // channels are always ready and match no channel below, so writes drop.
  always_comb begin
    cfg_ready_o = 1'b1;
    for (int c = 0; c < NumCh; c++) begin
      if (cfg_ch_i == ChW'(c)) cfg_ready_o = ~busy_q[c];
    end
  end

  assign cfg_fire = cfg_valid_i & cfg_ready_o;

  // Per-channel divider, strobe generation and pending-config apply.
  always_comb begin
    for (int c = 0; c < NumCh; c++) begin
      logic apply;
      apply       = 1'b0;
      cnt_d[c]    = cnt_q[c];
      half_d[c]   = half_q[c];
      half_p_d[c] = half_p_q[c];
      en_d[c]     = en_q[c];
      en_p_d[c]   = en_p_q[c];
      busy_d[c]   = busy_q[c];
      clk_d[c]    = clk_q[c];
      rise_d[c]   = 1'b0;
      fall_d[c]   = 1'b0;

      if (sync_w) begin
        if (en_q[c]) begin
          cnt_d[c]  = '0;
          clk_d[c]  = 1'b0;
          fall_d[c] = clk_q[c];
        end
        apply = busy_q[c];
      end else if (en_q[c]) begin
        if (cnt_q[c] == half_q[c] - One) begin
          cnt_d[c]  = '0;
          clk_d[c]  = ~clk_q[c];
          rise_d[c] = ~clk_q[c];
          fall_d[c] = clk_q[c];
          // Only the falling toggle closes a full period.
          apply     = busy_q[c] & clk_q[c];
        end else begin
          cnt_d[c] = cnt_q[c] + One;
        end
      end else begin
        cnt_d[c] = '0;
        clk_d[c] = 1'b0;
        apply    = busy_q[c];
      end

      if (apply) begin
        half_d[c] = half_p_q[c];
        en_d[c]   = en_p_q[c];
        busy_d[c] = 1'b0;
      end

      // Acceptance needs busy_q low, so it never collides with apply; a write
      // landing on a falling toggle waits for the next boundary.
      if (cfg_fire && (cfg_ch_i == ChW'(c))) begin
        half_p_d[c] = cfg_half_clamped;
        en_p_d[c]   = cfg_en_i;
        busy_d[c]   = 1'b1;
      end
    end
  end

  // State registers; reset discards any pending configuration.
  always_ff @(posedge clk_sys_in) begin
    if (rst_sys_in) begin
      for (int c = 0; c < NumCh; c++) begin
        cnt_q[c]    <= '0;
        half_q[c]   <= HalfRst;
        half_p_q[c] <= HalfRst;
      end
      en_q   <= '1;
      en_p_q <= '1;
      busy_q <= '0;
      clk_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int c = 0; c < NumCh; c++) begin
        cnt_q[c]    <= cnt_d[c];
        half_q[c]   <= half_d[c];
        half_p_q[c] <= half_p_d[c];
      end
      en_q   <= en_d;
      en_p_q <= en_p_d;
      busy_q <= busy_d;
      clk_q  <= clk_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign clk_o  = clk_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_chip_clk_gen.sv
// Bench for chip_clk_gen: expected strobe edges (channel, kind, cycle) are
// queued as stimulus is planned and popped as the DUT emits rise/fall.
module tb_chip_clk_gen;

  typedef struct {
    bit rise;
    int cyc;
  } exp_t;

  logic       clk_sys = 1'b0;
  logic       rst_sys;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [0:0] cfg_ch;
  logic [7:0] cfg_half;
  logic       cfg_en;
  logic       sync;
  logic [1:0] clk_o, rise_o, fall_o, busy_o;

  logic       cfg3_valid;
  logic       cfg3_ready;
  logic [1:0] cfg3_ch;
  logic [7:0] cfg3_half;
  logic       cfg3_en;
  logic [2:0] clk3, rise3, fall3, busy3;

  int   cyc;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[2][$];

  always #5 clk_sys = ~clk_sys;

  chip_clk_gen #(.NumCh(2), .DivWidth(8), .DefaultHalf(50)) u_dut (
    .clk_sys_in (clk_sys),
    .rst_sys_in (rst_sys),
    .cfg_valid_i(cfg_valid),
    .cfg_ready_o(cfg_ready),
    .cfg_ch_i   (cfg_ch),
    .cfg_half_i (cfg_half),
    .cfg_en_i   (cfg_en),
    .sync_i     (sync),
    .clk_o      (clk_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .busy_o     (busy_o)
  );

  chip_clk_gen #(.NumCh(3), .DivWidth(8), .DefaultHalf(5)) u_dut3 (
    .clk_sys_in (clk_sys),
    .rst_sys_in (rst_sys),
    .cfg_valid_i(cfg3_valid),
    .cfg_ready_o(cfg3_ready),
    .cfg_ch_i   (cfg3_ch),
    .cfg_half_i (cfg3_half),
    .cfg_en_i   (cfg3_en),
    .sync_i     (1'b0),
    .clk_o      (clk3),
    .rise_o     (rise3),
    .fall_o     (fall3),
    .busy_o     (busy3)
  );

  // Queue the edges of a clock whose first rise is at 'first' with half H,
  // restricted to cycles lo..hi.
  task automatic push_edges(input int ch, input int first, input int h,
                            input int lo, input int hi);
    exp_t e;
    for (int t = first; t <= hi; t += 2 * h) begin
      if (t >= lo) begin
        e.rise = 1'b1; e.cyc = t; exp_q[ch].push_back(e);
      end
      if (t + h >= lo && t + h <= hi) begin
        e.rise = 1'b0; e.cyc = t + h; exp_q[ch].push_back(e);
      end
    end
  endtask

  task automatic push_one(input int ch, input bit r, input int t);
    exp_t e;
    e.rise = r; e.cyc = t;
    exp_q[ch].push_back(e);
  endtask

  // Advance one clock and match any strobes against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk_sys);
    cyc++;
    @(negedge clk_sys);
    for (int c = 0; c < 2; c++) begin
      while (exp_q[c].size() > 0 && exp_q[c][0].cyc < cyc) begin
        e = exp_q[c].pop_front();
        checks++; errors++;
        $display("FAIL missed_edge ch%0d: expected rise=%0d at cycle %0d, got no strobe",
                 c, e.rise, e.cyc);
      end
      if (rise_o[c] || fall_o[c]) begin
        checks++;
        if (exp_q[c].size() == 0) begin
          errors++;
          $display("FAIL unexpected_edge ch%0d: got rise=%0d fall=%0d at cycle %0d, required none",
                   c, rise_o[c], fall_o[c], cyc);
        end else begin
          e = exp_q[c].pop_front();
          if (e.cyc !== cyc || e.rise !== rise_o[c] || fall_o[c] !== ~e.rise ||
              clk_o[c] !== e.rise) begin
            errors++;
            $display("FAIL edge ch%0d: got rise=%0d fall=%0d clk=%0d at cycle %0d, required rise=%0d at cycle %0d",
                     c, rise_o[c], fall_o[c], clk_o[c], cyc, e.rise, e.cyc);
          end
        end
      end
    end
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic test_reset();
    rst_sys = 1'b1;
    cyc = -100;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (clk_o !== 2'b00 || rise_o !== 2'b00 || fall_o !== 2'b00 ||
          busy_o !== 2'b00 || cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_state: got clk=%b rise=%b fall=%b busy=%b ready=%b, required 00 00 00 00 1",
                 clk_o, rise_o, fall_o, busy_o, cfg_ready);
      end
    end
    rst_sys = 1'b0;
    cyc = 0;
    push_edges(0, 50, 50, 1, 205);
    push_edges(1, 50, 50, 1, 205);
    run_to(49);
    checks++;
    if (clk_o !== 2'b00) begin
      errors++; $display("FAIL pre_first_rise: got clk=%b at cycle 49, required 00", clk_o);
    end
    run_to(99);
    checks++;
    if (clk_o !== 2'b11) begin
      errors++; $display("FAIL high_phase: got clk=%b at cycle 99, required 11", clk_o);
    end
    run_to(205);
  endtask

  task automatic test_reconfig();
    push_edges(0, 50, 50, 206, 300);
    push_edges(0, 303, 3, 301, 405);
    push_edges(1, 50, 50, 206, 405);
    run_to(260);
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_half = 8'd3; cfg_en = 1'b1;
    tick();
    checks++;
    if (busy_o !== 2'b01 || cfg_ready !== 1'b0) begin
      errors++; $display("FAIL reconfig_busy: got busy=%b ready=%b, required 01 0", busy_o, cfg_ready);
    end
    cfg_valid = 1'b0;
    run_to(299);
    checks++;
    if (busy_o[0] !== 1'b1) begin
      errors++; $display("FAIL reconfig_hold: got busy0=%b at cycle 299, required 1", busy_o[0]);
    end
    tick();
    checks++;
    if (busy_o !== 2'b00) begin
      errors++; $display("FAIL reconfig_apply: got busy=%b at cycle 300, required 00", busy_o);
    end
    run_to(405);
  endtask

  task automatic test_disable();
    push_edges(0, 303, 3, 406, 540);
    push_edges(1, 50, 50, 406, 500);
    push_edges(1, 523, 1, 501, 540);
    run_to(460);
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_half = 8'd50; cfg_en = 1'b0;
    tick();
    cfg_valid = 1'b0;
    run_to(470);
    checks++;
    if (busy_o[1] !== 1'b1 || cfg_ready !== 1'b0) begin
      errors++; $display("FAIL disable_pending: got busy1=%b ready=%b, required 1 0", busy_o[1], cfg_ready);
    end
    run_to(520);
    checks++;
    if (clk_o[1] !== 1'b0 || busy_o[1] !== 1'b0) begin
      errors++; $display("FAIL disabled_idle: got clk1=%b busy1=%b, required 0 0", clk_o[1], busy_o[1]);
    end
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_half = 8'd0; cfg_en = 1'b1;
    tick();
    cfg_valid = 1'b0;
    checks++;
    if (busy_o[1] !== 1'b1) begin
      errors++; $display("FAIL enable_busy: got busy1=%b at cycle 521, required 1", busy_o[1]);
    end
    tick();
    checks++;
    if (busy_o[1] !== 1'b0 || clk_o[1] !== 1'b0) begin
      errors++; $display("FAIL enable_apply: got busy1=%b clk1=%b at cycle 522, required 0 0",
                         busy_o[1], clk_o[1]);
    end
    run_to(540);
  endtask

  task automatic test_out_of_range();
    push_edges(0, 303, 3, 541, 565);
    push_edges(1, 523, 1, 541, 565);
    run_to(545);
    cfg3_valid = 1'b1; cfg3_ch = 2'd3; cfg3_half = 8'd2; cfg3_en = 1'b0;
    checks++;
    if (cfg3_ready !== 1'b1) begin
      errors++; $display("FAIL oor_ready: got ready=%b, required 1", cfg3_ready);
    end
    tick();
    cfg3_valid = 1'b0;
    while (cyc < 560) begin
      logic [2:0] want;
      want = ((cyc % 10) >= 5) ? 3'b111 : 3'b000;
      checks++;
      if (clk3 !== want || busy3 !== 3'b000) begin
        errors++; $display("FAIL oor_state: got clk=%b busy=%b at cycle %0d, required %b 000",
                           clk3, busy3, cyc, want);
      end
      tick();
    end
    run_to(565);
  endtask

  task automatic test_sync();
`ifdef CHIPCLK_SYNC_EN
    push_edges(0, 303, 3, 566, 568);
    push_one(0, 1'b0, 569);
    push_edges(0, 573, 4, 570, 601);
    push_edges(1, 523, 1, 566, 568);
    push_edges(1, 575, 6, 570, 601);
`else
    push_edges(0, 303, 3, 566, 570);
    push_edges(0, 574, 4, 571, 601);
    push_edges(1, 523, 1, 566, 570);
    push_edges(1, 576, 6, 571, 601);
`endif
    run_to(566);
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_half = 8'd4; cfg_en = 1'b1;
    tick();
    cfg_ch = 1'b1; cfg_half = 8'd6;
    checks++;
    if (busy_o[0] !== 1'b1) begin
      errors++; $display("FAIL sync_busy0: got busy0=%b at cycle 567, required 1", busy_o[0]);
    end
    tick();
    cfg_valid = 1'b0;
    sync = 1'b1;
    tick();
    sync = 1'b0;
    checks++;
`ifdef CHIPCLK_SYNC_EN
    if (clk_o !== 2'b00 || busy_o !== 2'b00) begin
      errors++; $display("FAIL sync_align: got clk=%b busy=%b at cycle 569, required 00 00", clk_o, busy_o);
    end
`else
    if (busy_o !== 2'b11) begin
      errors++; $display("FAIL sync_ignored: got busy=%b at cycle 569, required 11", busy_o);
    end
`endif
    run_to(590);
    checks++;
    if (busy_o !== 2'b00) begin
      errors++; $display("FAIL sync_applied: got busy=%b at cycle 590, required 00", busy_o);
    end
  endtask

  task automatic test_reset_mid();
    run_to(600);
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_half = 8'd2; cfg_en = 1'b1;
    tick();
    cfg_valid = 1'b0;
    checks++;
    if (busy_o[0] !== 1'b1) begin
      errors++; $display("FAIL midrst_pending: got busy0=%b at cycle 601, required 1", busy_o[0]);
    end
    rst_sys = 1'b1;
    tick();
    checks++;
    if (clk_o !== 2'b00 || rise_o !== 2'b00 || fall_o !== 2'b00 ||
        busy_o !== 2'b00 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_state: got clk=%b rise=%b fall=%b busy=%b ready=%b, required 00 00 00 00 1",
               clk_o, rise_o, fall_o, busy_o, cfg_ready);
    end
    rst_sys = 1'b0;
    cyc = 0;
    push_edges(0, 50, 50, 1, 105);
    push_edges(1, 50, 50, 1, 105);
    run_to(105);
    checks++;
    if (busy_o !== 2'b00 || exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
      errors++; $display("FAIL midrst_discard: got busy=%b pending_edges=%0d/%0d, required 00 0/0",
                         busy_o, exp_q[0].size(), exp_q[1].size());
    end
  endtask

  initial begin
    rst_sys = 1'b1;
    cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_half = 8'd0; cfg_en = 1'b0; sync = 1'b0;
    cfg3_valid = 1'b0; cfg3_ch = 2'd0; cfg3_half = 8'd0; cfg3_en = 1'b0;
    test_reset();
    test_reconfig();
    test_disable();
    test_out_of_range();
    test_sync();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
